// File: rtl/ldpc_muxreg_pipe.sv
// Multi-lane LLR select/sign-flip stage followed by a DEPTH-deep elastic register pipeline.
// Each lane picks one sign-magnitude LLR from din; beats move under valid/ready flow control.
module ldpc_muxreg_pipe #(
  parameter int LLRWIDTH = 4,
  parameter int NUMINPS  = 8,
  parameter int NUMOUTS  = 4,
  parameter int SELBITS  = 3,
  parameter int DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUMOUTS*SELBITS-1:0]   sel,
  input  logic [NUMOUTS-1:0]           neg,
  input  logic [NUMINPS*LLRWIDTH-1:0]  din,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUMOUTS*LLRWIDTH-1:0]  dout
);

  localparam int DW = NUMOUTS * LLRWIDTH;

  logic [DEPTH-1:0] v_q, v_d;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic             rst_done_q, rst_done_d;
  logic [DEPTH-1:0] adv;
  logic [DW-1:0]    lane_res;
  logic             accept;

  // NOTE: every variable driven here gets a default before any conditional
  // assignment; otherwise the unassigned paths would infer latches.
  always_comb begin
    lane_res = '0;
    for (int k = 0; k < NUMOUTS; k++) begin
      // Selects at or beyond NUMINPS match no input and leave the lane at zero.
      for (int i = 0; i < NUMINPS; i++) begin
        if (sel[k*SELBITS +: SELBITS] == SELBITS'(i)) begin
          lane_res[k*LLRWIDTH +: LLRWIDTH] = din[i*LLRWIDTH +: LLRWIDTH];
        end
      end
      if (neg[k] && (lane_res[k*LLRWIDTH +: LLRWIDTH-1] != '0)) begin
        lane_res[k*LLRWIDTH + LLRWIDTH-1] = ~lane_res[k*LLRWIDTH + LLRWIDTH-1];
      end
    end
  end

  // A stage advances when it or any stage downstream of it is empty, or the
  // sink takes the last one; this is the ready chain without a feedback loop.
  always_comb begin
    logic full_run;
    adv = '0;
    for (int s = 0; s < DEPTH; s++) begin
      full_run = 1'b1;
      for (int j = s; j < DEPTH; j++) begin
        full_run = full_run & v_q[j];
      end
      adv[s] = out_ready || !full_run;
    end
  end

  always_comb begin
    rst_done_d = 1'b1;
    in_ready   = rst_done_q && adv[0];
    accept     = in_valid && in_ready;
    v_d        = v_q;
    data_d     = data_q;
    if (adv[0]) begin
      v_d[0] = accept;
      if (accept) data_d[0] = lane_res;
    end
    for (int s = 1; s < DEPTH; s++) begin
      if (adv[s]) begin
        v_d[s] = v_q[s-1];
        if (v_q[s-1]) data_d[s] = data_q[s-1];
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour. Data registers are cleared on reset
  // too, because dout must read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q <= 1'b0;
      v_q        <= '0;
      for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
    end else begin
      rst_done_q <= rst_done_d;
      v_q        <= v_d;
      for (int s = 0; s < DEPTH; s++) data_q[s] <= data_d[s];
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign dout      = data_q[DEPTH-1];

endmodule

// File: tb/tb_ldpc_muxreg_pipe.sv
// Bench for ldpc_muxreg_pipe: three configurations share one stimulus bus, each
// checked every cycle against a queue-based transaction model plus literal pins.
module tb_ldpc_muxreg_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] sel = '0;
  logic [3:0]  neg = '0;
  logic [31:0] din = '0;
  logic [2:0]  ir, ov;
  logic [2:0][15:0] dq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rdy_m;

  // Model state: per instance, pending beats with expected data and earliest visible cycle.
  logic [15:0] qd [3][64];
  int          qt [3][64];
  int          head [3];
  int          tail [3];

  ldpc_muxreg_pipe u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .sel(sel), .neg(neg),
    .din(din), .out_valid(ov[0]), .out_ready(out_ready), .dout(dq[0]));

  ldpc_muxreg_pipe #(.NUMINPS(6), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .sel(sel), .neg(neg),
    .din(din[23:0]), .out_valid(ov[1]), .out_ready(out_ready), .dout(dq[1]));

  ldpc_muxreg_pipe #(.DEPTH(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .sel(sel), .neg(neg),
    .din(din), .out_valid(ov[2]), .out_ready(out_ready), .dout(dq[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_m <= 1'b0;
    else        rdy_m <= 1'b1;
  end

  function automatic int dep_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 1;
  endfunction

  function automatic int nin_of(input int k);
    return (k == 1) ? 6 : 8;
  endfunction

  function automatic logic [15:0] lane_model(input logic [31:0] d, input logic [11:0] s,
                                             input logic [3:0] n, input int ninp);
    logic [15:0] r;
    logic [3:0]  m;
    int          idx;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      idx = int'(s[k*3 +: 3]);
      m   = (idx < ninp) ? d[idx*4 +: 4] : 4'h0;
      if (n[k] && m[2:0] != 3'b000) m[3] = ~m[3];
      r[k*4 +: 4] = m;
    end
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: runs on the falling edge, when all outputs are settled.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int cnt;
      bit eov, eir;
      if (!rst_n) begin
        check(ov[k] == 1'b0, $sformatf("rst_out_valid%0d", k), 32'(ov[k]), 0);
        check(ir[k] == 1'b0, $sformatf("rst_in_ready%0d", k), 32'(ir[k]), 0);
        check(dq[k] == 16'h0, $sformatf("rst_dout%0d", k), 32'(dq[k]), 0);
        head[k] = 0;
        tail[k] = 0;
      end else begin
        cnt = tail[k] - head[k];
        eov = (cnt > 0) && (qt[k][head[k] % 64] <= cyc);
        eir = rdy_m && !(cnt == dep_of(k) && !out_ready);
        check(ov[k] == eov, $sformatf("out_valid%0d", k), 32'(ov[k]), 32'(eov));
        check(ir[k] == eir, $sformatf("in_ready%0d", k), 32'(ir[k]), 32'(eir));
        if (eov && ov[k])
          check(dq[k] == qd[k][head[k] % 64], $sformatf("dout%0d", k), 32'(dq[k]),
                32'(qd[k][head[k] % 64]));
        if (eov && out_ready) begin
          head[k]++;
          if (tail[k] > head[k] && qt[k][head[k] % 64] < cyc + 1)
            qt[k][head[k] % 64] = cyc + 1;
        end
        if (in_valid && eir) begin
          qd[k][tail[k] % 64] = lane_model(din, sel, neg, nin_of(k));
          qt[k][tail[k] % 64] = cyc + dep_of(k);
          tail[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one beat into an empty pipe and pins the exact latency and result of instance k.
  task automatic one_beat(input int k, input logic [31:0] d, input logic [11:0] s,
                          input logic [3:0] n, input logic [15:0] exp);
    in_valid = 1'b1; din = d; sel = s; neg = n; out_ready = 1'b1;
    #1;
    check(ir[k] == 1'b1, "one_beat_ready", 32'(ir[k]), 1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < dep_of(k); i++) begin
      check(ov[k] == 1'b0, "latency_early", 32'(ov[k]), 0);
      tick();
    end
    check(ov[k] == 1'b1, "latency_exact", 32'(ov[k]), 1);
    check(dq[k] == exp, "beat_value", 32'(dq[k]), 32'(exp));
    repeat (5) tick();
  endtask

  initial begin
    int nb, nd;
    int drops [3];
    int dels [3];
    bit stalled_prev;
    logic [15:0] prev_d;

    // Reset state and release
    #12;
    check(ov[0] == 1'b0, "reset_out_valid", 32'(ov[0]), 0);
    check(dq[0] == 16'h0, "reset_dout", 32'(dq[0]), 0);
    check(ir[0] == 1'b0, "reset_in_ready", 32'(ir[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check(ir[0] == 1'b0, "ready_before_first_edge", 32'(ir[0]), 0);
    tick();
    check(ir[0] == 1'b1, "ready_after_first_edge", 32'(ir[0]), 1);

    // Basic selection and latency on each configuration
    one_beat(0, 32'h87654321, 12'h5D8, 4'h0, 16'h3841);
    one_beat(1, 32'h87654321, 12'h5D8, 4'h0, 16'h3041);
    one_beat(2, 32'h87654321, 12'h5D8, 4'h0, 16'h3841);

    // Sign flip, including a magnitude-zero lane that must stay +0
    one_beat(0, 32'h00000B03, 12'h088, 4'hF, 16'hB30B);

    // Out-of-range selects on the six-input instance
    one_beat(1, 32'hFFFFFFFF, 12'hFBE, 4'hF, 16'h0000);
    one_beat(1, 32'hFFFFFFFF, 12'hFBE, 4'h0, 16'h0000);
    one_beat(0, 32'hFFFFFFFF, 12'hFBE, 4'hF, 16'h7777);

    // Back-pressure: 10 beats, sink stalled for cycles 3..8
    nb = 0; nd = 0; stalled_prev = 1'b0; prev_d = '0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 8);
      in_valid  = (nb < 10);
      din       = {8{4'(nb + 1)}};
      sel       = 12'h688;
      neg       = 4'h0;
      #1;
      if (c == 8) check(ir[0] == 1'b0, "bp_ready_low_when_full", 32'(ir[0]), 0);
      if (stalled_prev) check(dq[0] == prev_d, "bp_dout_stable", 32'(dq[0]), 32'(prev_d));
      stalled_prev = ov[0] && !out_ready;
      prev_d = dq[0];
      if (ov[0] && out_ready) begin
        check(dq[0] == {4{4'(nd + 1)}}, "bp_order", 32'(dq[0]), 32'({4{4'(nd + 1)}}));
        nd++;
      end
      if (in_valid && ir[0]) nb++;
      tick();
    end
    in_valid = 1'b0;
    check(nd == 10, "bp_delivered_count", 32'(nd), 10);

    // Full throughput: 100 beats with the sink always ready
    out_ready = 1'b1;
    repeat (6) tick();
    for (int k = 0; k < 3; k++) begin drops[k] = 0; dels[k] = 0; end
    for (int c = 0; c < 104; c++) begin
      in_valid = (c < 100);
      din = $urandom; sel = 12'($urandom); neg = 4'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (in_valid && !ir[k]) drops[k]++;
        if (ov[k] && c < 100 + dep_of(k)) dels[k]++;
      end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check(drops[k] == 0, $sformatf("tput_ready_drops%0d", k), 32'(drops[k]), 0);
      check(dels[k] == 100, $sformatf("tput_delivered%0d", k), 32'(dels[k]), 100);
    end

    // Asynchronous reset with beats in flight
    repeat (6) tick();
    out_ready = 1'b0; in_valid = 1'b1; din = 32'hCAFE1234; sel = 12'h688; neg = 4'h0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check(ov[k] == 1'b0, $sformatf("async_out_valid%0d", k), 32'(ov[k]), 0);
      check(dq[k] == 16'h0, $sformatf("async_dout%0d", k), 32'(dq[k]), 0);
      check(ir[k] == 1'b0, $sformatf("async_in_ready%0d", k), 32'(ir[k]), 0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check(ov[0] == 1'b0, "no_stale_beat", 32'(ov[0]), 0);
      tick();
    end
    one_beat(0, 32'h12345678, 12'h688, 4'b0101, 16'h5E78);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = (c < 1000) ? ($urandom_range(2) != 0) : ($urandom_range(3) == 0);
      din = $urandom; sel = 12'($urandom); neg = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldpc_muxreg_pipe.md
Name: ldpc_muxreg_pipe

Overview:
- Multi-lane, elastic successor to the single-lane LLR mux-register.
- Each of NUMOUTS output lanes independently selects one of NUMINPS sign-magnitude LLR inputs, with an optional per-lane sign flip.
- The result passes through a DEPTH-stage registered pipeline with valid/ready back-pressure.
- Sits between the LLR message RAM read ports and the check/variable node arrays, and replaces ad-hoc mux+register pairs where back-pressure is required.

Parameters:
- LLRWIDTH, 4: bits per LLR, sign-magnitude; MSB is the sign.
- NUMINPS, 8: number of input LLRs on din.
- NUMOUTS, 4: number of independent output lanes.
- SELBITS, 3: select width per lane; must satisfy 2^SELBITS >= NUMINPS.
- DEPTH, 2: pipeline register stages, legal range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  din/sel/neg are valid this cycle
- in_ready  out  1  block accepts the beat this cycle
- sel  in  NUMOUTS*SELBITS  per-lane input index; lane k uses bits [k*SELBITS +: SELBITS]
- neg  in  NUMOUTS  per-lane sign-flip enable
- din  in  NUMINPS*LLRWIDTH  packed LLRs; input i uses bits [i*LLRWIDTH +: LLRWIDTH]
- out_valid  out  1  dout holds a valid beat
- out_ready  in  1  downstream accepts dout
- dout  out  NUMOUTS*LLRWIDTH  packed lane results; lane k uses bits [k*LLRWIDTH +: LLRWIDTH]

Behaviour:
- Reset
  - rst_n low clears every stage valid bit and every data register to 0 immediately, without waiting for clk.
  - During reset: out_valid=0, dout=0, in_ready=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
  - Reset mid-transfer discards all in-flight beats; none are emitted afterwards.
- Handshake
  - A beat is accepted when in_valid && in_ready on a rising edge.
  - A beat is delivered when out_valid && out_ready.
  - dout stays stable while out_valid && !out_ready.
- Lane function, evaluated at stage 0:
  - m = din[sel_k].
  - If sel_k >= NUMINPS, m = 0.
  - If neg_k=1 and m[LLRWIDTH-2:0] != 0, the MSB of m is inverted.
  - Magnitude-zero values are never negated, so -0 is never produced.
  - Lanes are fully independent; two lanes may select the same input.
- Pipeline
  - Stages s0..s(DEPTH-1), each holding a valid bit and NUMOUTS*LLRWIDTH data bits. Only s0 stores the lane function result.
  - Stage s(DEPTH-1) drives out_valid and dout.
  - Stage s advances (loads from s-1, or from input for s0) when it is empty, or when its content moves on in the same cycle.
  - in_ready = !v0 || s0 advances; this is a combinational ready chain back from out_ready.
  - When a stage empties with nothing entering, its valid bit clears; data is don't-care but holds its value.
- Latency
  - Accept to first out_valid is exactly DEPTH cycles (beat accepted at edge n is visible after edge n+DEPTH-1).
  - With out_ready held high, throughput is 1 beat/cycle and no bubbles are inserted.
- Capacity: up to DEPTH beats in flight.
  - With all stages full and out_ready=0, in_ready=0.
  - When out_ready rises, in_ready rises in the same cycle.
- Ordering: beats exit in acceptance order; no loss or duplication under any valid/ready pattern.
- Simultaneous accept and deliver on a full pipe: both occur and occupancy is unchanged.
- in_valid may deassert at any time; sel/neg/din are sampled only on accept.

Test Plan:
1. Reset and latency, defaults: rst_n=0 -> out_valid=0, dout=0, in_ready=0. Release, then accept beat din=0x87654321 (input i holds value i+1), sel lanes={0,3,7,2}, neg=0, with out_ready=1 -> after 2 cycles out_valid=1, dout lanes={1,4,8,3}.
2. Sign flip: din input0=0x3, input1=0x0, input2=0xB; lanes sel={0,1,2,0}, neg=4'b1111 -> lanes={0xB,0x0,0x3,0xB}; lane1 stays 0x0, no -0.
3. Out-of-range select, NUMINPS=6, SELBITS=3: sel=6 and sel=7 -> lane=0 regardless of neg.
4. Back-pressure: stream 10 beats with incrementing data; out_ready=0 for cycles 3..8 -> in_ready=0 once 2 beats are held; all 10 beats exit in order exactly once, dout stable while stalled.
5. Full throughput, DEPTH=1 and DEPTH=4: continuous in_valid with out_ready=1 for 100 beats -> 100 beats out in 100+DEPTH-1 cycles, and in_ready never drops.
6. Async reset mid-stream: assert rst_n between edges with 2 beats in flight -> out_valid and dout go to 0 immediately; after release, no stale beat appears and the next accepted beat emerges after DEPTH cycles.
